// File: rtl/io_ack_pkg.sv
// Shared state/class types and the MA[14:11] device decode for the I/O acknowledge sequencer.
package io_ack_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, ACK, FAULT, RECOVER} state_t;
    typedef enum logic [1:0] {FAST, RTC, UNMAPPED} dev_class_t;

    localparam int CNT_MAX = 255;

    function automatic dev_class_t dev_class(input logic [3:0] ma);
        dev_class_t c;
        casez (ma)
            4'b0?0?: c = FAST;
            4'b0011: c = FAST;
            4'b0111: c = RTC;
            default: c = UNMAPPED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/io_dev_decode.sv
// Combinational I/O cycle decode: device class plus read/write/illegal qualifiers gated by CS5.
module io_dev_decode
    import io_ack_pkg::*;
(
    input  logic       cs5,
    input  logic       rdio_n,
    input  logic       wrio_n,
    input  logic [3:0] ma,
    output dev_class_t cls,
    output logic       rd,
    output logic       wr,
    output logic       illegal
);

    assign cls     = dev_class(ma);
    assign rd      = cs5 & ~rdio_n &  wrio_n;
    assign wr      = cs5 &  rdio_n & ~wrio_n;
    assign illegal = cs5 & ~rdio_n & ~wrio_n;

endmodule

// File: rtl/io_ack_sequencer.sv
// Clocked I/O acknowledge / 58167 strobe sequencer with wait-state counting, bus-error timeout
// and enforced RTC recovery time. Every output is a flop.
module io_ack_sequencer
    import io_ack_pkg::*;
#(
    parameter int WS_FAST     = 2,
    parameter int WS_RTC      = 12,
    parameter int RTC_RECOVER = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       CS5,
    input  logic       RDIO_n,
    input  logic       WRIO_n,
    input  logic [3:0] MA,
    output logic       IOACK_n,
    output logic       BERR_n,
    output logic       RDRTC_n,
    output logic       WRRTC_n,
    output logic       BUSY
);

    if (WS_FAST > CNT_MAX || WS_RTC > CNT_MAX || RTC_RECOVER > CNT_MAX || TIMEOUT > CNT_MAX) begin : g_param_check
        $error("io_ack_sequencer: timing parameter exceeds the 8-bit counter range");
    end

    localparam logic [7:0] WS_FAST_C     = WS_FAST[7:0];
    localparam logic [7:0] WS_RTC_C      = WS_RTC[7:0];
    localparam logic [7:0] RTC_RECOVER_C = RTC_RECOVER[7:0];
    localparam logic [7:0] TIMEOUT_C     = TIMEOUT[7:0];

    state_t     state;
    dev_class_t cls;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic [7:0] limit;

    dev_class_t dec_cls;
    logic       dec_rd;
    logic       dec_wr;
    logic       dec_illegal;

    io_dev_decode u_decode (
        .cs5     (CS5),
        .rdio_n  (RDIO_n),
        .wrio_n  (WRIO_n),
        .ma      (MA),
        .cls     (dec_cls),
        .rd      (dec_rd),
        .wr      (dec_wr),
        .illegal (dec_illegal)
    );

    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    always_comb begin
        limit = TIMEOUT_C;
        case (cls)
            FAST:    limit = WS_FAST_C;
            RTC:     limit = WS_RTC_C;
            default: limit = TIMEOUT_C;
        endcase
    end

    // Strobes are loaded together with the state so they change on the same edge as the state.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state   <= IDLE;
            cls     <= FAST;
            cnt     <= 8'd0;
            IOACK_n <= 1'b1;
            BERR_n  <= 1'b1;
            RDRTC_n <= 1'b1;
            WRRTC_n <= 1'b1;
            BUSY    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dec_illegal) begin
                        state  <= FAULT;
                        BERR_n <= 1'b0;
                        BUSY   <= 1'b1;
                    end else if (dec_rd || dec_wr) begin
                        state   <= WAIT;
                        cls     <= dec_cls;
                        cnt     <= 8'd1;
                        BUSY    <= 1'b1;
                        RDRTC_n <= !((dec_cls == RTC) && dec_rd);
                        WRRTC_n <= !((dec_cls == RTC) && dec_wr);
                    end
                end
                WAIT: begin
                    // An abort wins over a completion landing on the same edge.
                    if (!CS5) begin
                        RDRTC_n <= 1'b1;
                        WRRTC_n <= 1'b1;
                        if (cls == RTC) begin
                            state <= RECOVER;
                            cnt   <= 8'd1;
                        end else begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                            BUSY  <= 1'b0;
                        end
                    end else if (cnt >= limit) begin
                        WRRTC_n <= 1'b1;
                        if (cls == UNMAPPED) begin
                            state  <= FAULT;
                            BERR_n <= 1'b0;
                        end else begin
                            state   <= ACK;
                            IOACK_n <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ACK: begin
                    if (!CS5) begin
                        IOACK_n <= 1'b1;
                        RDRTC_n <= 1'b1;
                        if (cls == RTC) begin
                            state <= RECOVER;
                            cnt   <= 8'd1;
                        end else begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                            BUSY  <= 1'b0;
                        end
                    end
                end
                FAULT: begin
                    if (!CS5) begin
                        state  <= IDLE;
                        cnt    <= 8'd0;
                        BERR_n <= 1'b1;
                        BUSY   <= 1'b0;
                    end
                end
                RECOVER: begin
                    if (cnt >= RTC_RECOVER_C) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_ack_sequencer.sv
// Self-checking bench: directed and random I/O cycles compared edge by edge against a timeline model.
module tb_io_ack_sequencer;

    localparam int WS_FAST     = 2;
    localparam int WS_RTC      = 12;
    localparam int RTC_RECOVER = 4;
    localparam int TIMEOUT     = 64;

    logic       CLK     = 1'b0;
    logic       RESET_n = 1'b0;
    logic       CS5     = 1'b0;
    logic       RDIO_n  = 1'b1;
    logic       WRIO_n  = 1'b1;
    logic [3:0] MA      = 4'h0;
    logic       IOACK_n;
    logic       BERR_n;
    logic       RDRTC_n;
    logic       WRRTC_n;
    logic       BUSY;

    int compared   = 0;
    int mismatched = 0;
    int edge_no    = 0;
    int free_edge  = 0;
    int prev_end   = 0;

    io_ack_sequencer #(
        .WS_FAST     (WS_FAST),
        .WS_RTC      (WS_RTC),
        .RTC_RECOVER (RTC_RECOVER),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .CS5     (CS5),
        .RDIO_n  (RDIO_n),
        .WRIO_n  (WRIO_n),
        .MA      (MA),
        .IOACK_n (IOACK_n),
        .BERR_n  (BERR_n),
        .RDRTC_n (RDRTC_n),
        .WRRTC_n (WRRTC_n),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s edge %0d: got %b, expected %b", tag, edge_no, observed, expected);
        end
    endtask

    task automatic checkAll(input logic ack, input logic berr, input logic rd, input logic wr, input logic busy);
        checkOutput("IOACK_n", IOACK_n, ack);
        checkOutput("BERR_n", BERR_n, berr);
        checkOutput("RDRTC_n", RDRTC_n, rd);
        checkOutput("WRRTC_n", WRRTC_n, wr);
        checkOutput("BUSY", BUSY, busy);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_no++;
    endtask

    // kind: 0 = read, 1 = write, 2 = both qualifiers low. len = edges CS5 is seen high from the start edge.
    task automatic applyStimulus(input logic [3:0] ma, input int kind, input int len, input int gap);
        int  arrive, start, drop, ws, txn_end, k;
        bit  legal, is_rtc, is_fast;
        logic rd_n, wr_n;
        logic e_ack, e_berr, e_rd, e_wr, e_busy;
        legal   = (kind != 2);
        is_rtc  = legal && (ma == 4'h7);
        is_fast = legal && (ma inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h3});
        ws      = is_rtc ? WS_RTC : (is_fast ? WS_FAST : TIMEOUT);
        rd_n    = !(kind == 0 || kind == 2);
        wr_n    = !(kind == 1 || kind == 2);
        arrive  = edge_no + gap;
        start   = (arrive > free_edge) ? arrive : free_edge;
        drop    = start + len;
        txn_end = drop + (is_rtc ? RTC_RECOVER : 0);
        for (int e = edge_no; e <= drop; e++) begin
            CS5 = (e >= arrive) && (e < drop);
            if (e >= arrive && e <= start) begin
                MA     = ma;
                RDIO_n = rd_n;
                WRIO_n = wr_n;
            end else begin
                MA     = 4'($urandom);
                RDIO_n = 1'($urandom);
                WRIO_n = 1'($urandom);
            end
            tick();
            k      = e - start;
            e_busy = (e < start) ? (e < prev_end) : (e < txn_end);
            e_ack  = !((is_rtc || is_fast) && len > ws && k >= ws && k < len);
            e_berr = legal ? !(!is_rtc && !is_fast && len > ws && k >= ws && k < len)
                           : !(k >= 0 && k < len);
            e_rd   = !(is_rtc && kind == 0 && k >= 0 && k < len);
            e_wr   = !(is_rtc && kind == 1 && k >= 0 && k < len && k < ws);
            checkAll(e_ack, e_berr, e_rd, e_wr, e_busy);
        end
        prev_end  = txn_end;
        free_edge = txn_end + 1;
    endtask

    initial begin
        int kind, len, gap, r;
        logic [3:0] ma;

        #12;
        checkAll(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        CS5 = 1'b1; RDIO_n = 1'b0;
        tick();
        tick();
        checkAll(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        CS5 = 1'b0; RDIO_n = 1'b1;
        RESET_n = 1'b1;
        free_edge = edge_no;
        prev_end  = edge_no;

        applyStimulus(4'h0, 0, 5, 0);
        applyStimulus(4'h7, 1, 16, 1);
        applyStimulus(4'h8, 0, 70, 2);
        applyStimulus(4'h7, 0, 5, 1);
        applyStimulus(4'h7, 0, 14, 0);
        applyStimulus(4'h7, 0, 14, 1);
        applyStimulus(4'h3, 1, 3, 0);
        applyStimulus(4'h6, 1, 8, 0);
        applyStimulus(4'h5, 2, 3, 0);

        for (int n = 0; n < 150; n++) begin
            r    = $urandom_range(0, 9);
            kind = (r == 0) ? 2 : ((r <= 5) ? 0 : 1);
            r    = $urandom_range(0, 3);
            ma   = (r == 0) ? 4'h7 : 4'($urandom);
            r    = $urandom_range(0, 3);
            len  = (r == 0) ? $urandom_range(1, 4) : (r == 1) ? $urandom_range(10, 16)
                 : (r == 2) ? $urandom_range(60, 70) : $urandom_range(2, 6);
            gap  = $urandom_range(0, 3);
            applyStimulus(ma, kind, len, gap);
        end

        applyStimulus(4'h0, 0, 1, 8);

        // Asynchronous reset in the middle of an RTC write wait.
        MA = 4'h7; RDIO_n = 1'b1; WRIO_n = 1'b0; CS5 = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("WRRTC_n mid-wait", WRRTC_n, 1'b0);
        checkOutput("BUSY mid-wait", BUSY, 1'b1);
        #2;
        RESET_n = 1'b0;
        #1;
        checkAll(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        CS5 = 1'b0; WRIO_n = 1'b1;
        tick();
        RESET_n = 1'b1;
        tick();
        checkAll(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        free_edge = edge_no;
        prev_end  = edge_no;
        applyStimulus(4'h2, 2, 3, 0);
        applyStimulus(4'h7, 0, 13, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
